seq_mul_div_unit: RTL and testbench

Iterative unsigned multiply/divide engine with a start/done handshake. It replaces the single-cycle combinational mul/div functions where timing or area matters. A requester issues operands and an opcode; the unit computes in WIDTH cycles and returns registered results. Multiply is shift-add; divide is restoring (the inverse operation, sharing the same control FSM and iteration counter).

---
 rtl/seq_mul_div_unit.sv | 118 +++++++++++
 tb/tb_seq_mul_div_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One shared FSM and iteration counter; results are registered and held between completions.
module seq_mul_div_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;      // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;

    logic               last;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               sub_ok;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   q_nxt;

    assign last     = (cnt == CW'(1));
    assign busy     = (state != IDLE);

    assign acc_nxt  = opa[0] ? acc + mcand : acc;

    // Shifted partial remainder needs one extra bit before the compare.
    assign rem_sh   = {rem, opa[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign sub_ok   = (rem_sh >= {1'b0, opb});
    assign rem_nxt  = sub_ok ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign q_nxt    = {opa[WIDTH-2:0], sub_ok};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = op ? DIV : MUL;
            MUL, DIV: if (last)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            opa         <= '0;
            opb         <= '0;
            rem         <= '0;
            acc         <= '0;
            mcand       <= '0;
            done        <= 1'b0;
            product     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        rem   <= '0;
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, b};
                        cnt   <= CW'(WIDTH);
                    end
                end
                MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    opa   <= opa >> 1;
                    cnt   <= cnt - CW'(1);
                    if (last) begin
                        product     <= acc_nxt;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    opa <= q_nxt;
                    cnt <= cnt - CW'(1);
                    // b==0 falls out naturally: every compare succeeds, giving all-ones / a.
                    if (last) begin
                        quotient    <= q_nxt;
                        remainder   <= rem_nxt;
                        div_by_zero <= (opb == '0);
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_div_unit.sv
// Scoreboard bench for seq_mul_div_unit: expectations queued at issue, checked on done.
module tb_seq_mul_div_unit;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             op = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             busy, done, div_by_zero;
    logic [2*W-1:0]   product;
    logic [W-1:0]     quotient, remainder;

    seq_mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .product(product), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] p;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           z;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [2*W-1:0] m_p = '0;
    logic [W-1:0]   m_q = '0;
    logic [W-1:0]   m_r = '0;
    logic           m_z = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", product, e.p);
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                chk("latency", cyc, e.cyc);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        if (!busy) begin
            if (!o) begin
                m_p = x * y;
                m_z = 1'b0;
            end else if (y == 0) begin
                m_q = '1;
                m_r = x;
                m_z = 1'b1;
            end else begin
                m_q = x / y;
                m_r = x % y;
                m_z = 1'b0;
            end
            e.p = m_p; e.q = m_q; e.r = m_r; e.z = m_z; e.cyc = cyc + 1 + W;
            sb.push_back(e);
        end
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!done) chk("timeout", done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

        // 1: multiply 5*5
        issue(0, 5, 5);
        chk("busy_after_start", busy, 1);
        wait_done(); @(negedge clk);

        // 2: divides and max multiply
        issue(1, 15, 3);   wait_done(); @(negedge clk);
        issue(1, 200, 7);  wait_done(); @(negedge clk);
        issue(0, 255, 255); wait_done(); @(negedge clk);

        // 3: divide by zero then multiply clears the flag
        issue(1, 42, 0);   wait_done(); @(negedge clk);
        issue(0, 3, 4);    wait_done(); @(negedge clk);

        // 4: start ignored while busy, then back-to-back in done cycle
        issue(0, 5, 5);
        @(negedge clk);
        chk("busy_mid", busy, 1);
        issue(0, 9, 9);
        wait_done();
        issue(0, 6, 7);
        wait_done(); @(negedge clk);

        // 5: reset mid-divide aborts
        issue(1, 100, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        m_p = '0; m_q = '0; m_r = '0; m_z = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        repeat (12) @(negedge clk);
        issue(1, 100, 3);  wait_done(); @(negedge clk);

        // 6: operand changes during busy are ignored
        issue(0, 10, 10);
        a = '0; b = '0; op = 1'b1;
        wait_done(); @(negedge clk);

        // a few random ops
        for (int i = 0; i < 6; i++) begin
            issue(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_done(); @(negedge clk);
        end

        repeat (12) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
